// File: rtl/wishbone_fifo_slave.sv
// wishbone_fifo_slave: Wishbone classic mailbox with a bus-to-native TX FIFO and a native-to-bus RX FIFO
//   clk_i/rst_i : clock, asynchronous active-high reset
//   wb_*        : Wishbone classic slave port (DATA=0, STATUS=1, CONTROL=2 by wb_adr_i[3:2])
//   tx_*        : valid/ready source draining the TX FIFO
//   rx_*        : valid/ready sink filling the RX FIFO
module wishbone_fifo_slave #(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, ACK} state_e;
  state_e state_q, state_d;
  logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] tx_mem [DEPTH];
  logic [31:0] rx_mem [DEPTH];
  logic [1:0] adr;
  logic req, tx_full, tx_empty, rx_full, rx_empty;
  logic data_wr, data_rd, ctl_wr;
  logic tx_push, tx_pop, rx_push, rx_pop, flush_tx, flush_rx, clr;
  logic [31:0] status;
  logic unused;
  assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1]};
  assign wb_ack_o = state_q == ACK;
  assign wb_dat_o = wb_ack_o ? dat_q : 32'd0;
  assign tx_valid_o = !tx_empty;
  assign rx_ready_o = !rx_full;
  assign tx_data_o = tx_mem[tx_rd_q];
  always_comb begin
    adr = wb_adr_i[3:2];
    // a strobe still high during ACK is the tail of the current access, not a new one
    req = state_q == IDLE && wb_cyc_i && wb_stb_i;
    tx_full = tx_cnt_q == CNT_W'(DEPTH);
    tx_empty = tx_cnt_q == '0;
    rx_full = rx_cnt_q == CNT_W'(DEPTH);
    rx_empty = rx_cnt_q == '0;
    data_wr = req && wb_we_i && adr == 2'd0;
    data_rd = req && !wb_we_i && adr == 2'd0;
    ctl_wr = req && wb_we_i && adr == 2'd2 && wb_sel_i[0];
    // fullness is judged before any same-edge native pop
    tx_push = data_wr && !tx_full;
    tx_pop = tx_valid_o && tx_ready_i;
    rx_push = rx_valid_i && rx_ready_o;
    rx_pop = data_rd && !rx_empty;
    flush_tx = ctl_wr && wb_dat_i[0];
    flush_rx = ctl_wr && wb_dat_i[1];
    clr = ctl_wr && wb_dat_i[2];
    status = {8'd0, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'd0, rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
    tx_wr_d = flush_tx ? '0 : tx_wr_q + PW'(tx_push);
    tx_rd_d = flush_tx ? '0 : tx_rd_q + PW'(tx_pop);
    tx_cnt_d = flush_tx ? '0 : tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
    rx_wr_d = flush_rx ? '0 : rx_wr_q + PW'(rx_push);
    rx_rd_d = flush_rx ? '0 : rx_rd_q + PW'(rx_pop);
    rx_cnt_d = flush_rx ? '0 : rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    tx_ovf_d = clr ? 1'b0 : tx_ovf_q | (data_wr && tx_full);
    rx_unf_d = clr ? 1'b0 : rx_unf_q | (data_rd && rx_empty);
    dat_d = rx_pop ? rx_mem[rx_rd_q] : (req && !wb_we_i && adr == 2'd1) ? status : 32'd0;
    state_d = req ? ACK : IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      tx_cnt_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      rx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      dat_q <= 32'd0;
    end else begin
      state_q <= state_d;
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      dat_q <= dat_d;
    end
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_q] <= wb_dat_i;
    if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
  end
endmodule

// File: tb/tb_wishbone_fifo_slave.sv
// tb_wishbone_fifo_slave: randomized and directed checks of wishbone_fifo_slave against a queue-based model
module tb_wishbone_fifo_slave;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0;
  logic [31:0] dat = 0, adr = 0, rx_data = 0;
  logic [3:0] sel = 0;
  logic cyc = 0, stb = 0, we = 0, tx_ready = 0, rx_valid = 0;
  logic [31:0] wb_dat_o, tx_data_o;
  logic wb_ack_o, tx_valid_o, rx_ready_o;
  int n_cmp = 0, n_err = 0;
  logic [31:0] tx_q[$], rx_q[$];
  bit m_ovf, m_unf, m_busy, m_ack;
  logic [31:0] m_dat;
  always #5 clk = ~clk;
  wishbone_fifo_slave #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .wb_dat_i(dat), .wb_dat_o(wb_dat_o), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(wb_ack_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o));
  function automatic logic [31:0] m_status();
    return {8'd0, 8'(rx_q.size()), 8'(tx_q.size()), 2'd0, m_unf, m_ovf,
            rx_q.size() == DEPTH, rx_q.size() == 0, tx_q.size() == DEPTH, tx_q.size() == 0};
  endfunction
  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 0; m_unf = 0; m_busy = 0; m_ack = 0; m_dat = 0;
  endtask
  // advance one clock edge and apply the mailbox rules to the model, then settle 1 time unit
  task automatic tick();
    bit req, txpop, rxpush, tpush, rpop, ftx, frx;
    logic [31:0] nd;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      req = !m_busy && cyc && stb;
      txpop = tx_q.size() != 0 && tx_ready;
      rxpush = rx_valid && rx_q.size() < DEPTH;
      tpush = 0; rpop = 0; ftx = 0; frx = 0; nd = 0;
      if (req)
        case (adr[3:2])
          2'd0: if (we) begin
                  if (tx_q.size() == DEPTH) m_ovf = 1; else tpush = 1;
                end else if (rx_q.size() == 0) m_unf = 1;
                else begin nd = rx_q[0]; rpop = 1; end
          2'd1: if (!we) nd = m_status();
          2'd2: if (we && sel[0]) begin
                  ftx = dat[0]; frx = dat[1];
                  if (dat[2]) begin m_ovf = 0; m_unf = 0; end
                end
          default: ;
        endcase
      if (ftx) tx_q.delete();
      else begin
        if (txpop) void'(tx_q.pop_front());
        if (tpush) tx_q.push_back(dat);
      end
      if (frx) rx_q.delete();
      else begin
        if (rpop) void'(rx_q.pop_front());
        if (rxpush) rx_q.push_back(rx_data);
      end
      m_busy = req; m_ack = req; m_dat = nd;
    end
    #1;
  endtask
  // one complete access: request edge, then the ack edge with the strobe dropped
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output bit ack1, output logic [31:0] rd, output bit ack2);
    cyc = 1; stb = 1; we = w; adr = a; dat = d; sel = s;
    tick();
    ack1 = wb_ack_o; rd = wb_dat_o;
    cyc = 0; stb = 0; we = 0;
    tick();
    ack2 = wb_ack_o;
  endtask
  task automatic test_reset();
    bit a1, a2;
    logic [31:0] rd;
    rst = 1; cyc = 1; stb = 1;
    #3;
    model_reset();
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b exp 0", wb_ack_o); end
    n_cmp++; if (wb_dat_o !== 32'd0) begin n_err++; $display("FAIL reset_dat: got %h exp 0", wb_dat_o); end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid_o); end
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b exp 1", rx_ready_o); end
    tick();
    tick();
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL reset_hold_ack: got %b exp 0", wb_ack_o); end
    rst = 0; cyc = 0; stb = 0;
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL reset_status_ack1: got %b exp 1", a1); end
    n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL reset_status: got %h exp 00000005", rd); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL reset_status_ack_len: got %b exp 0", a2); end
  endtask
  task automatic test_tx_basic();
    bit a1, a2;
    logic [31:0] rd;
    tx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus(1, 0, 32'hA5A5_0001 + i, 4'hf, a1, rd, a2);
      n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL tx_wr_ack%0d: got %b exp 1", i, a1); end
    end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0304) begin n_err++; $display("FAIL tx3_status: got %h exp 00000304", rd); end
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tx_valid_o !== 1'b1) begin n_err++; $display("FAIL tx_drain_valid%0d: got %b exp 1", i, tx_valid_o); end
      n_cmp++; if (tx_data_o !== 32'hA5A5_0001 + i) begin n_err++; $display("FAIL tx_drain_data%0d: got %h exp %h", i, tx_data_o, 32'hA5A5_0001 + i); end
      tick();
    end
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL tx_drained_valid: got %b exp 0", tx_valid_o); end
    tx_ready = 0;
  endtask
  task automatic test_tx_overflow();
    bit a1, a2;
    logic [31:0] rd;
    logic [31:0] w[9];
    int n;
    tx_ready = 0;
    for (int i = 0; i < 9; i++) begin
      w[i] = $urandom;
      bus(1, 0, w[i], 4'h0, a1, rd, a2);
      n_cmp++; if (a1 !== 1'b1) begin n_err++; $display("FAIL ovf_wr_ack%0d: got %b exp 1", i, a1); end
    end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0816) begin n_err++; $display("FAIL ovf_status: got %h exp 00000816", rd); end
    tx_ready = 1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (tx_valid_o) begin
        n_cmp++; if (n > 7 || tx_data_o !== w[n > 8 ? 8 : n]) begin n_err++; $display("FAIL ovf_drain_word%0d: got %h", n, tx_data_o); end
        n++;
      end
      tick();
    end
    tx_ready = 0;
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL ovf_drain_count: got %0d exp 8", n); end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0015) begin n_err++; $display("FAIL ovf_sticky: got %h exp 00000015", rd); end
    bus(1, 32'h8, 32'h4, 4'h1, a1, rd, a2);
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL ovf_clear: got %h exp 00000005", rd); end
  endtask
  task automatic test_rx();
    bit a1, a2;
    logic [31:0] rd;
    logic [31:0] f[8];
    rx_valid = 1; rx_data = 32'h11;
    tick();
    rx_data = 32'h22;
    tick();
    rx_valid = 0;
    bus(0, 0, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h11) begin n_err++; $display("FAIL rx_rd0: got %h exp 00000011", rd); end
    bus(0, 0, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h22) begin n_err++; $display("FAIL rx_rd1: got %h exp 00000022", rd); end
    bus(0, 0, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (a1 !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL rx_underflow_rd: got ack %b data %h exp ack 1 data 0", a1, rd); end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0025) begin n_err++; $display("FAIL rx_underflow_status: got %h exp 00000025", rd); end
    rx_valid = 1;
    for (int i = 0; i < 8; i++) begin
      f[i] = $urandom; rx_data = f[i];
      tick();
    end
    rx_valid = 0;
    n_cmp++; if (rx_ready_o !== 1'b0) begin n_err++; $display("FAIL rx_full_ready: got %b exp 0", rx_ready_o); end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0008_0029) begin n_err++; $display("FAIL rx_full_status: got %h exp 00080029", rd); end
    bus(0, 0, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== f[0]) begin n_err++; $display("FAIL rx_full_rd: got %h exp %h", rd, f[0]); end
    n_cmp++; if (rx_ready_o !== 1'b1) begin n_err++; $display("FAIL rx_unfull_ready: got %b exp 1", rx_ready_o); end
    bus(1, 32'h8, 32'h6, 4'h1, a1, rd, a2);
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL rx_flush_clear: got %h exp 00000005", rd); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] w;
    tx_ready = 1; cyc = 1; stb = 1; we = 1; adr = 0; sel = 4'hf;
    for (int i = 0; i < 20; i++) begin
      w = $urandom; dat = w;
      tick();
      n_cmp++; if (wb_ack_o !== 1'b1 || tx_valid_o !== 1'b1 || tx_data_o !== w) begin n_err++; $display("FAIL b2b_push%0d: got ack %b valid %b data %h exp 1 1 %h", i, wb_ack_o, tx_valid_o, tx_data_o, w); end
      tick();
      n_cmp++; if (wb_ack_o !== 1'b0 || tx_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap%0d: got ack %b valid %b exp 0 0", i, wb_ack_o, tx_valid_o); end
    end
    cyc = 0; stb = 0; we = 0; tx_ready = 0;
  endtask
  task automatic test_flush();
    bit a1, a2;
    logic [31:0] rd;
    tx_ready = 0;
    for (int i = 0; i < 4; i++) bus(1, 0, $urandom, 4'hf, a1, rd, a2);
    rx_valid = 1;
    for (int i = 0; i < 4; i++) begin rx_data = $urandom; tick(); end
    rx_valid = 0;
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0004_0400) begin n_err++; $display("FAIL flush_pre_status: got %h exp 00040400", rd); end
    bus(1, 32'h8, 32'h3, 4'he, a1, rd, a2);
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0004_0400) begin n_err++; $display("FAIL flush_sel_gate: got %h exp 00040400", rd); end
    cyc = 1; stb = 1; we = 1; adr = 32'h8; dat = 32'h3; sel = 4'h1;
    rx_valid = 1; rx_data = $urandom; tx_ready = 1;
    tick();
    cyc = 0; stb = 0; we = 0; rx_valid = 0; tx_ready = 0;
    n_cmp++; if (tx_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_tx_valid: got %b exp 0", tx_valid_o); end
    tick();
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL flush_status: got %h exp 00000005", rd); end
  endtask
  task automatic test_random();
    int r;
    logic [1:0] a;
    for (int c = 0; c < 600; c++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = $urandom;
      r = $urandom_range(0, 19);
      a = r < 14 ? 2'd0 : r < 17 ? 2'd1 : r < 18 ? 2'd2 : 2'd3;
      adr = ($urandom & 32'hFFFF_FFF3) | {28'd0, a, 2'b00};
      we = 1'($urandom_range(0, 1));
      dat = a == 2'd2 ? 32'($urandom_range(0, 7)) : $urandom;
      sel = 4'($urandom);
      cyc = 1'($urandom_range(0, 1));
      stb = cyc & 1'($urandom_range(0, 1));
      tick();
      n_cmp++; if (wb_ack_o !== m_ack) begin n_err++; $display("FAIL rnd_ack@%0d: got %b exp %b", c, wb_ack_o, m_ack); end
      n_cmp++; if (wb_dat_o !== (m_ack ? m_dat : 32'd0)) begin n_err++; $display("FAIL rnd_dat@%0d: got %h exp %h", c, wb_dat_o, m_ack ? m_dat : 32'd0); end
      n_cmp++; if (tx_valid_o !== (tx_q.size() != 0)) begin n_err++; $display("FAIL rnd_tx_valid@%0d: got %b exp %b", c, tx_valid_o, tx_q.size() != 0); end
      if (tx_q.size() != 0) begin
        n_cmp++; if (tx_data_o !== tx_q[0]) begin n_err++; $display("FAIL rnd_tx_data@%0d: got %h exp %h", c, tx_data_o, tx_q[0]); end
      end
      n_cmp++; if (rx_ready_o !== (rx_q.size() < DEPTH)) begin n_err++; $display("FAIL rnd_rx_ready@%0d: got %b exp %b", c, rx_ready_o, rx_q.size() < DEPTH); end
    end
    cyc = 0; stb = 0; we = 0; tx_ready = 0; rx_valid = 0;
    tick();
    tick();
  endtask
  task automatic test_rst_pending();
    bit a1, a2;
    logic [31:0] rd;
    tx_ready = 0;
    bus(1, 0, $urandom, 4'hf, a1, rd, a2);
    rx_valid = 1; rx_data = $urandom;
    tick();
    rx_valid = 0;
    cyc = 1; stb = 1; we = 0; adr = 0;
    #3;
    rst = 1;
    model_reset();
    #1;
    n_cmp++; if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'd0) begin n_err++; $display("FAIL rstp_bus: got ack %b data %h exp 0 0", wb_ack_o, wb_dat_o); end
    n_cmp++; if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin n_err++; $display("FAIL rstp_fifo: got tx_valid %b rx_ready %b exp 0 1", tx_valid_o, rx_ready_o); end
    tick();
    tick();
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rstp_hold_ack: got %b exp 0", wb_ack_o); end
    rst = 0; cyc = 0; stb = 0;
    tick();
    n_cmp++; if (wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rstp_after_ack: got %b exp 0", wb_ack_o); end
    bus(0, 32'h4, 0, 4'hf, a1, rd, a2);
    n_cmp++; if (rd !== 32'h0000_0005) begin n_err++; $display("FAIL rstp_status: got %h exp 00000005", rd); end
  endtask
  initial begin
    test_reset();
    test_tx_basic();
    test_tx_overflow();
    test_rx();
    test_back_to_back();
    test_flush();
    test_random();
    test_rst_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wishbone_fifo_slave.md
Name: wishbone_fifo_slave

Overview:
Wishbone classic responder that exposes a bidirectional mailbox to bus masters through the wishbone interconnect.
- Bus writes to DATA push a TX FIFO, which drains to a native valid/ready consumer.
- A native producer fills an RX FIFO, which bus reads of DATA pop.
- STATUS and CONTROL registers give occupancy, sticky error flags and flush control.
- Peripheral-side endpoint on an interconnect slave port, in place of the memory-backed slave.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2..128.
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
wb_dat_i  in  32  write data from interconnect
wb_dat_o  out  32  read data to interconnect
wb_adr_i  in  32  byte address; only [3:2] decoded
wb_sel_i  in  4  byte selects
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_ack_o  out  1  acknowledge
tx_data_o  out  32  TX FIFO head
tx_valid_o  out  1  TX FIFO not empty
tx_ready_i  in  1  consumer accepts tx_data_o
rx_data_i  in  32  producer data
rx_valid_i  in  1  producer data valid
rx_ready_o  out  1  RX FIFO not full

Behaviour:
- Reset (async, rst_i=1): both FIFOs empty, pointers and counts 0, sticky flags 0, wb_ack_o=0, wb_dat_o=0, tx_valid_o=0, rx_ready_o=1. An in-flight bus access is dropped without ack. Outputs hold reset values while rst_i=1.
- Register map, by wb_adr_i[3:2]:
  - 0 DATA: write pushes TX; read pops RX.
  - 1 STATUS: read-only; writes ignored.
  - 2 CONTROL: write-only, self-clearing; reads return 0.
  - 3 reserved: reads 0, writes ignored.
- STATUS bits:
  - [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full
  - [4] tx_overflow (sticky), [5] rx_underflow (sticky)
  - [15:8] tx_count, [23:16] rx_count (zero-extended); other bits 0.
- CONTROL bits: [0] flush TX, [1] flush RX, [2] clear sticky flags. Acted on only when wb_sel_i[0]=1.
- Bus FSM:
  - IDLE: on cyc&stb, perform the access this edge, register read data, go to ACK.
  - ACK: wb_ack_o=1 for exactly one cycle, wb_dat_o valid; then return to IDLE.
  - Strobe still high during ACK is not a new request. Back-to-back accesses therefore complete at most every 2 cycles; latency is 1 cycle from request to ack.
  - wb_dat_o is 0 whenever wb_ack_o=0. cyc low while in ACK still completes the ack cycle.
- DATA write pushes the full 32-bit word, ignoring wb_sel_i.
  - If TX is full (evaluated before any same-cycle pop): word dropped, tx_overflow set, ack still given.
- DATA read returns the RX head and pops it.
  - If RX is empty: returns 0, rx_underflow set, ack still given.
- Native TX: pop when tx_valid_o&tx_ready_i. Native RX: push when rx_valid_i&rx_ready_o.
- Simultaneous bus push and native pop on TX (not full): both occur, count unchanged. Same rule for RX native push plus bus pop.
- Flush has priority over a same-cycle native pop/push on that FIFO: pointers and count go to 0.
- Pointers wrap modulo DEPTH. Full = count==DEPTH.

Test Plan:
- Reset then idle: STATUS read = 0x00000005, ack 1 cycle after stb, tx_valid_o=0, rx_ready_o=1.
- Write 0xA5A5_0001..0xA5A5_0003 to DATA with tx_ready_i=0, read STATUS -> tx_count=3 (0x00000300 | rx_empty). Raise tx_ready_i -> tx_data_o sequence 0xA5A5_0001,2,3, then tx_valid_o=0.
- DEPTH=8: push 9 writes with tx_ready_i=0 -> 9th dropped, STATUS bit4=1, bit1=1. Drain -> exactly 8 words out. CONTROL write 0x4 -> bit4 cleared.
- Producer pushes 0x11,0x22 -> DATA reads return 0x11 then 0x22. A third read returns 0 and sets bit5. Filling 8 entries drops rx_ready_o to 0.
- Wrap and concurrency: stream 20 words through TX with bus writes and tx_ready_i=1 every cycle -> order preserved, count never exceeds 1.
- CONTROL 0x3 with both FIFOs holding 4 entries -> both counts 0, tx_valid_o=0. Assert rst_i during a pending access -> no ack, all outputs at reset values.
